// File: rtl/ps2_key_event.sv
// PS/2 keyboard front end: synchronizes the raw lines, receives 11-bit frames,
// decodes make/break/E0 sequences, tracks shift and queues key-make events.
module ps2_key_event #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_code,
  output logic        evt_ext,
  output logic        shift,
  output logic [18:0] press_count,
  output logic        overflow,
  output logic        frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  logic [2:0]    clk_sync;
  logic [2:0]    data_sync;
  logic          fall;
  logic          sample;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] idle_cnt;
  logic          frame_ok;
  logic          rx_valid;
  logic [7:0]    rx_byte;

  state_t        state_reg;
  state_t        state_next;
  logic          push;
  logic [8:0]    push_data;
  logic          lshift_set, lshift_clr, rshift_set, rshift_clr;
  logic          lshift_reg, rshift_reg;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push_ok;
  logic [8:0]    head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign sample = data_sync[2];

  // On the 11th edge shreg holds start (bit 0), data (8:1) and parity (9); sample is the stop bit.
  assign frame_ok = ~shreg[0] & sample & (^shreg[9:1]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt   <= 4'd0;
      shreg     <= 10'd0;
      idle_cnt  <= '0;
      rx_valid  <= 1'b0;
      rx_byte   <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            rx_valid <= 1'b1;
            rx_byte  <= shreg[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {sample, shreg[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT - 1)) begin
          bit_cnt  <= 4'd0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (rx_valid) begin
      case (state_reg)
        IDLE: begin
          if (rx_byte == 8'hE0)      state_next = EXT;
          else if (rx_byte == 8'hF0) state_next = BRK;
        end
        EXT: begin
          if (rx_byte == 8'hF0)      state_next = EXT_BRK;
          else if (rx_byte != 8'hE0) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    push       = 1'b0;
    push_data  = 9'd0;
    lshift_set = 1'b0;
    lshift_clr = 1'b0;
    rshift_set = 1'b0;
    rshift_clr = 1'b0;
    if (rx_valid) begin
      case (state_reg)
        IDLE: begin
          case (rx_byte)
            8'hE0, 8'hF0, 8'hAA, 8'hFA: ;
            8'h12:   lshift_set = 1'b1;
            8'h59:   rshift_set = 1'b1;
            default: begin
              push      = 1'b1;
              push_data = {1'b0, rx_byte};
            end
          endcase
        end
        EXT: begin
          if (rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
            push      = 1'b1;
            push_data = {1'b1, rx_byte};
          end
        end
        BRK: begin
          lshift_clr = (rx_byte == 8'h12);
          rshift_clr = (rx_byte == 8'h59);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lshift_reg <= 1'b0;
      rshift_reg <= 1'b0;
    end else begin
      if (lshift_set)      lshift_reg <= 1'b1;
      else if (lshift_clr) lshift_reg <= 1'b0;
      if (rshift_set)      rshift_reg <= 1'b1;
      else if (rshift_clr) rshift_reg <= 1'b0;
    end
  end

  assign shift = lshift_reg | rshift_reg;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ~empty & evt_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign evt_valid = ~empty;
  assign evt_code  = empty ? 8'd0 : head[7:0];
  assign evt_ext   = empty ? 1'b0 : head[8];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      press_count <= 19'd0;
      overflow    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr      <= wr_ptr + 1'b1;
        press_count <= press_count + 19'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & full & ~pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_key_event;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ps2_clk;
  logic        ps2_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_code;
  logic        evt_ext;
  logic        shift;
  logic [18:0] press_count;
  logic        overflow;
  logic        frame_err;

  int vectors = 0;
  int miscompares = 0;
  int err_cycles = 0;
  logic [8:0] got [$];

  ps2_key_event #(.FIFO_DEPTH(8), .TIMEOUT(200)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .shift(shift), .press_count(press_count),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Record every accepted head and every frame_err cycle.
  always @(negedge clk) begin
    if (resetn === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1)
      got.push_back({evt_ext, evt_code});
    if (frame_err === 1'b1) err_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit chk_lat);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      if (chk_lat && i == 10) begin
        repeat (3) @(posedge clk);
        #1 chk("lat_low", 32'(evt_valid), 32'd0);
        @(posedge clk);
        #1 chk("lat_high", 32'(evt_valid), 32'd1);
        chk("lat_code", 32'(evt_code), 32'(b));
        chk("lat_ext", 32'(evt_ext), 32'd0);
        repeat (6) @(negedge clk);
      end else begin
        repeat (10) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  task automatic chk_q(input string tag, input int idx, input logic [8:0] exp);
    chk(tag, (got.size() > idx) ? 32'(got[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    logic [7:0] codes [9];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    resetn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_code", 32'(evt_code), 0);
    chk("rst_ext", 32'(evt_ext), 0);
    chk("rst_shift", 32'(shift), 0);
    chk("rst_count", 32'(press_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Make, break of same key: one event, exact latency
    evt_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 11, 1'b1);
    send(8'hF0); send(8'h1C);
    repeat (10) @(negedge clk);
    chk("mk_qsize", got.size(), 1);
    chk_q("mk_ev", 0, 9'h01C);
    chk("mk_count", 32'(press_count), 1);

    // Extended make then extended break
    got.delete();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    repeat (10) @(negedge clk);
    chk("ext_qsize", got.size(), 1);
    chk_q("ext_ev", 0, 9'h175);
    chk("ext_count", 32'(press_count), 2);

    // Shift held around a key
    got.delete();
    send(8'h12);
    chk("shift_on", 32'(shift), 1);
    send(8'h1C);
    send(8'hF0); send(8'h12);
    chk("shift_off", 32'(shift), 0);
    repeat (10) @(negedge clk);
    chk("sh_qsize", got.size(), 1);
    chk_q("sh_ev", 0, 9'h01C);
    chk("sh_count", 32'(press_count), 3);

    // Bad parity rejected with a single-cycle pulse
    got.delete(); err_cycles = 0;
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    repeat (10) @(negedge clk);
    chk("par_err", err_cycles, 1);
    chk("par_qsize", got.size(), 0);
    chk("par_count", 32'(press_count), 3);

    // Partial frame abandoned by timeout, then a clean frame
    err_cycles = 0;
    send_frame(8'h55, 1'b0, 4, 1'b0);
    repeat (250) @(negedge clk);
    send(8'h2A);
    repeat (10) @(negedge clk);
    chk("to_err", err_cycles, 0);
    chk("to_qsize", got.size(), 1);
    chk_q("to_ev", 0, 9'h02A);

    // Self-test / ack bytes ignored
    got.delete();
    send(8'hAA); send(8'hFA);
    repeat (10) @(negedge clk);
    chk("ign_qsize", got.size(), 0);
    chk("ign_count", 32'(press_count), 4);

    // Overflow: 9 makes into a depth-8 FIFO with no consumer
    @(posedge clk); #1 evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(codes[i]);
    repeat (10) @(negedge clk);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(press_count), 12);
    chk("ovf_head", 32'(evt_code), 32'h15);
    @(posedge clk); #1 evt_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain_qsize", got.size(), 8);
    for (int i = 0; i < 8; i++) chk_q("drain_ev", i, {1'b0, codes[i]});
    chk("drain_valid", 32'(evt_valid), 0);

    // Reset in the middle of a frame
    got.delete();
    send_frame(8'h66, 1'b0, 5, 1'b0);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_valid", 32'(evt_valid), 0);
    chk("mrst_code", 32'(evt_code), 0);
    chk("mrst_shift", 32'(shift), 0);
    chk("mrst_count", 32'(press_count), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h29);
    repeat (10) @(negedge clk);
    chk("mrst_qsize", got.size(), 1);
    chk_q("mrst_ev", 0, 9'h029);
    chk("mrst_count2", 32'(press_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
